// File: rtl/arb_pkg.sv
// Shared types and sizes for the 8-requester arbiter.
// Round-robin build: define ARB_ROUND_ROBIN_EN.
package arb_pkg;

  localparam int NREQ = 8;
  localparam int IDW  = 3;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

endpackage

// File: rtl/prio_enc8_core.sv
// Combinational 8-to-3 priority encoder, bit 7 highest.
// valid is low when disabled or when no bit is set.
module prio_enc8_core
  import arb_pkg::*;
(
  input  logic            en,
  input  logic [NREQ-1:0] vec,
  output logic [IDW-1:0]  idx,
  output logic            valid
);

  always_comb begin
    idx   = '0;
    valid = en && (|vec);
    priority case (1'b1)
      vec[7]:  idx = 3'd7;
      vec[6]:  idx = 3'd6;
      vec[5]:  idx = 3'd5;
      vec[4]:  idx = 3'd4;
      vec[3]:  idx = 3'd3;
      vec[2]:  idx = 3'd2;
      vec[1]:  idx = 3'd1;
      vec[0]:  idx = 3'd0;
      default: idx = '0;
    endcase
  end

endmodule

// File: rtl/prio_arbiter8.sv
// 8-requester arbiter: hold until release, one dead cycle, hold timeout.
// Define ARB_ROUND_ROBIN_EN for rotating priority; default is fixed.
module prio_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EN,
  input  logic [NREQ-1:0] REQ,
  output logic [NREQ-1:0] GNT,
  output logic [IDW-1:0]  GID,
  output logic            GV,
  output logic            TO
);

  state_t           state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]  mask_q, mask_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic             gv_q, gv_d;
  logic             to_q, to_d;

  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  enc_in;
  logic [IDW-1:0]   enc_idx;
  logic             enc_vld;
  logic [IDW-1:0]   win;
  logic             hold_hit;
  logic             own_req;

  assign elig     = REQ & ~mask_q;
  assign own_req  = REQ[gid_q];
  assign hold_hit = (MAX_HOLD != 0) &&
                    (cnt_q == HOLD_W'(MAX_HOLD - 1));

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDW-1:0] ptr_q, ptr_d;

  // Encoder bit 7 sees index ptr, bit 6 sees ptr+1, and so on.
  always_comb begin
    enc_in = '0;
    for (int j = 0; j < NREQ; j++) begin
      enc_in[j] = elig[IDW'(ptr_q - IDW'(j) - 3'd1)];
    end
  end

  assign win = IDW'(ptr_q - enc_idx - 3'd1);
`else
  assign enc_in = elig;
  assign win    = enc_idx;
`endif

  prio_enc8_core u_enc (
    .en    (EN),
    .vec   (enc_in),
    .idx   (enc_idx),
    .valid (enc_vld)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    gid_d   = gid_q;
    gv_d    = 1'b0;
    to_d    = 1'b0;
    mask_d  = mask_q & REQ;
`ifdef ARB_ROUND_ROBIN_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (enc_vld) begin
          state_d = GRANT;
          gnt_d   = NREQ'(1) << win;
          gid_d   = win;
          gv_d    = 1'b1;
          cnt_d   = '0;
`ifdef ARB_ROUND_ROBIN_EN
          ptr_d   = win + 3'd1;
`endif
        end
      end
      GRANT: begin
        cnt_d = cnt_q + HOLD_W'(1);
        if (!own_req) begin
          state_d = GAP;
        end else if (hold_hit) begin
          state_d       = GAP;
          to_d          = 1'b1;
          mask_d[gid_q] = 1'b1;
        end else begin
          gnt_d = gnt_q;
          gv_d  = 1'b1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      gnt_q   <= '0;
      gid_q   <= '0;
      gv_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      gnt_q   <= gnt_d;
      gid_q   <= gid_d;
      gv_q    <= gv_d;
      to_q    <= to_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign GNT = gnt_q;
  assign GID = gid_q;
  assign GV  = gv_q;
  assign TO  = to_q;

endmodule
